aes_v2_round_seq: RTL and testbench

- Initiator-side sequencer for the aes_v2 instruction unit (sub/mix, valid/ready).
- Computes one full AES round on a 128-bit state by issuing per-column sub and mix operations to the unit, then XORs the round key.
- Sits between a block-cipher controller (request/response, 128-bit) and one aes_v2 instance, which it drives exactly as a CPU pipeline would.

---
 rtl/aes_v2_round_seq_pkg.sv | 33 +++
 rtl/aes_v2_round_seq_shiftsel.sv | 18 +
 rtl/aes_v2_round_seq.sv | 124 ++++++++++++
 tb/tb_aes_v2_round_seq.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_v2_round_seq_pkg.sv
// Shared types and byte/column helpers for the aes_v2 round sequencer.
// Byte k of a 128-bit state sits at [8k+7:8k]; column c is bytes 4c..4c+3.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_MIX  = 2'd2,
    ST_DONE = 2'd3
  } fsm_e;

  // ShiftRows pulls row r of output column c from column c+r; the inverse from c-r.
  function automatic logic [1:0] src_col_enc(input logic [1:0] c, input logic [1:0] r);
    return c + r;
  endfunction

  function automatic logic [1:0] src_col_dec(input logic [1:0] c, input logic [1:0] r);
    return c - r;
  endfunction

  function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] c);
    return s[32*c +: 32];
  endfunction

  function automatic logic [127:0] set_col(input logic [127:0] s, input logic [1:0] c,
                                           input logic [31:0] w);
    logic [127:0] r;
    r = s;
    r[32*c +: 32] = w;
    return r;
  endfunction

endpackage

// File: rtl/aes_v2_round_seq_shiftsel.sv
// Gathers the four (Inv)ShiftRows source bytes for output column col_i into one word.
// Purely combinational; row r lands in word_o[8r+7:8r].
module aes_v2_shiftsel
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [1:0]   col_i,
  input  logic         enc_i,
  output logic [31:0]  word_o
);

  for (genvar r = 0; r < 4; r++) begin : g_row
    logic [1:0] src;
    assign src = enc_i ? src_col_enc(col_i, 2'(r)) : src_col_dec(col_i, 2'(r));
    assign word_o[8*r +: 8] = state_i[32*src + 8*r +: 8];
  end

endmodule

// File: rtl/aes_v2_round_seq.sv
// One AES round (or equivalent-inverse round) by issuing per-column sub/mix ops to an external aes_v2 unit.
// Zero-wait unit: response 9 cycles after accept (5 for a last round); operands held stable while the unit stalls.
module aes_v2_round_seq
  import aes_pkg::*;
#(
  parameter bit KEY_XOR = 1'b1
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_enc,
  input  logic         req_last,
  input  logic [127:0] req_state,
  input  logic [127:0] req_key,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_state,
  output logic         aes_valid,
  output logic         aes_sub,
  output logic         aes_enc,
  output logic [31:0]  aes_rs1,
  output logic [31:0]  aes_rs2,
  input  logic         aes_ready,
  input  logic [31:0]  aes_rd
);

  fsm_e         fsm_q;
  logic [1:0]   col_q;
  logic [127:0] state_q;
  logic [127:0] key_q;
  logic [127:0] res_q;
  logic [127:0] res_d;
  logic         enc_q;
  logic         last_q;
  logic         aes_valid_q;
  logic         aes_sub_q;
  logic [31:0]  rs_q;
  logic         rsp_valid_q;

  logic [127:0] key_in;
  logic [127:0] sel_state;
  logic [1:0]   sel_col;
  logic         sel_enc;
  logic [31:0]  sel_word;
  logic         col_done;

  assign key_in = KEY_XOR ? req_key : '0;

  // Operand for the next sub op: from the incoming request in IDLE, else the following column.
  assign sel_state = (fsm_q == ST_IDLE) ? req_state : state_q;
  assign sel_col   = (fsm_q == ST_IDLE) ? 2'd0 : col_q + 2'd1;
  assign sel_enc   = (fsm_q == ST_IDLE) ? req_enc : enc_q;

  aes_v2_shiftsel u_shiftsel (
    .state_i (sel_state),
    .col_i   (sel_col),
    .enc_i   (sel_enc),
    .word_o  (sel_word)
  );

  assign col_done = aes_ready && ((fsm_q == ST_MIX) || (fsm_q == ST_SUB && last_q));
  assign res_d    = set_col(res_q, col_q, aes_rd ^ get_col(key_q, col_q));

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      fsm_q       <= ST_IDLE;
      col_q       <= 2'd0;
      state_q     <= '0;
      key_q       <= '0;
      res_q       <= '0;
      enc_q       <= 1'b0;
      last_q      <= 1'b0;
      aes_valid_q <= 1'b0;
      aes_sub_q   <= 1'b0;
      rs_q        <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      if (fsm_q == ST_IDLE && req_valid) begin
        state_q     <= req_state;
        key_q       <= key_in;
        enc_q       <= req_enc;
        last_q      <= req_last;
        col_q       <= 2'd0;
        fsm_q       <= ST_SUB;
        aes_valid_q <= 1'b1;
        aes_sub_q   <= 1'b1;
        rs_q        <= sel_word;
      end
      if (fsm_q == ST_SUB && aes_ready && !last_q) begin
        fsm_q     <= ST_MIX;
        aes_sub_q <= 1'b0;
        rs_q      <= aes_rd;
      end
      if (col_done) begin
        res_q <= res_d;
        if (col_q == 2'd3) begin
          fsm_q       <= ST_DONE;
          aes_valid_q <= 1'b0;
          rsp_valid_q <= 1'b1;
        end else begin
          col_q     <= col_q + 2'd1;
          fsm_q     <= ST_SUB;
          aes_sub_q <= 1'b1;
          rs_q      <= sel_word;
        end
      end
      if (fsm_q == ST_DONE && rsp_ready) begin
        fsm_q       <= ST_IDLE;
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign req_ready = (fsm_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_state = res_q;
  assign aes_valid = aes_valid_q;
  assign aes_sub   = aes_sub_q;
  assign aes_enc   = enc_q;
  assign aes_rs1   = rs_q;
  assign aes_rs2   = rs_q;

endmodule

// File: tb/tb_aes_v2_round_seq.sv
// Directed bench for aes_v2_round_seq with a behavioural aes_v2 unit (S-box derived from GF(2^8) inverse).
// Unit responds on the falling edge with optional random 0-3 wait cycles.
module tb_aes_v2_round_seq;

  logic         g_clk;
  logic         g_resetn;
  logic         req_valid;
  logic         req_ready;
  logic         req_enc;
  logic         req_last;
  logic [127:0] req_state;
  logic [127:0] req_key;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_state;
  logic         aes_valid;
  logic         aes_sub;
  logic         aes_enc;
  logic [31:0]  aes_rs1;
  logic [31:0]  aes_rs2;
  logic         aes_ready = 1'b0;
  logic [31:0]  aes_rd = '0;

  aes_v2_round_seq #(.KEY_XOR(1'b1)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_enc(req_enc), .req_last(req_last),
    .req_state(req_state), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_state(rsp_state),
    .aes_valid(aes_valid), .aes_sub(aes_sub), .aes_enc(aes_enc),
    .aes_rs1(aes_rs1), .aes_rs2(aes_rs2), .aes_ready(aes_ready), .aes_rd(aes_rd)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  int nvec = 0;
  int nmis = 0;

  logic [7:0] sbox  [256];
  logic [7:0] isbox [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] w, input logic enc);
    logic [7:0] a0, a1, a2, a3;
    logic [31:0] r;
    a0 = w[7:0]; a1 = w[15:8]; a2 = w[23:16]; a3 = w[31:24];
    if (enc) begin
      r[7:0]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      r[15:8]  = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      r[23:16] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      r[31:24] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end else begin
      r[7:0]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      r[15:8]  = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      r[23:16] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      r[31:24] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return r;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] b, input logic enc);
    return enc ? sbox[b] : isbox[b];
  endfunction

  // Unit behaviour: sub reads rs1/rs2 byte lanes alternately, mix reads {rs2[31:16], rs1[15:0]}.
  function automatic logic [31:0] unit_op(input logic sub, input logic enc,
                                          input logic [31:0] rs1, input logic [31:0] rs2);
    if (sub)
      return {sb(rs2[31:24], enc), sb(rs1[23:16], enc), sb(rs2[15:8], enc), sb(rs1[7:0], enc)};
    return mixcol({rs2[31:16], rs1[15:0]}, enc);
  endfunction

  // Writes bytes listed 0..15 left-to-right into the byte-k-at-[8k+7:8k] layout.
  function automatic logic [127:0] bs(input logic [127:0] x);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = x[8*(15-k) +: 8];
    return r;
  endfunction

  // Unit model and stall-hold monitor
  bit          rand_wait = 1'b0;
  bit          in_op = 1'b0;
  bit          stalled_prev = 1'b0;
  logic [1:0]  wait_left = 2'd0;
  logic        h_sub, h_enc;
  logic [31:0] h_rs1, h_rs2;
  int          sub_cnt = 0, mix_cnt = 0, stall_cnt = 0, hold_errs = 0;

  always @(negedge g_clk) begin
    if (stalled_prev && g_resetn === 1'b1) begin
      if (aes_valid !== 1'b1 || aes_sub !== h_sub || aes_enc !== h_enc ||
          aes_rs1 !== h_rs1 || aes_rs2 !== h_rs2)
        hold_errs++;
    end
    if (aes_valid !== 1'b1) begin
      in_op = 1'b0;
      aes_ready = 1'b0;
    end else begin
      if (!in_op || aes_ready) begin
        in_op = 1'b1;
        wait_left = rand_wait ? 2'($urandom_range(0, 3)) : 2'd0;
      end else if (wait_left != 2'd0) begin
        wait_left = wait_left - 2'd1;
      end
      aes_ready = (wait_left == 2'd0);
      if (aes_ready) begin
        if (aes_sub) sub_cnt++;
        else mix_cnt++;
      end else begin
        stall_cnt++;
      end
    end
    stalled_prev = (aes_valid === 1'b1) && !aes_ready;
    h_sub = aes_sub; h_enc = aes_enc; h_rs1 = aes_rs1; h_rs2 = aes_rs2;
    aes_rd = unit_op(aes_sub, aes_enc, aes_rs1, aes_rs2);
  end

  typedef struct {
    logic         enc;
    logic         last;
    logic [127:0] st;
    logic [127:0] key;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[4];
  int   sub0, mix0, stl0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge g_clk); #1; n++;
    end
    check({nm, "_req_ready"}, req_ready, 1);
  endtask

  task automatic issue(input vec_t v);
    req_valid = 1'b1;
    req_enc   = v.enc;
    req_last  = v.last;
    req_state = v.st;
    req_key   = v.key;
    @(posedge g_clk);
    sub0 = sub_cnt; mix0 = mix_cnt; stl0 = stall_cnt;
    #1 req_valid = 1'b0;
  endtask

  task automatic finish(input vec_t v, input string nm, input bit release_rsp);
    int lat = 1;
    int base;
    while (rsp_valid !== 1'b1 && lat < 200) begin
      @(posedge g_clk); #1; lat++;
    end
    check({nm, "_rsp_valid"}, rsp_valid, 1);
    check({nm, "_state"}, rsp_state, v.exp);
    base = v.last ? 5 : 9;
    check({nm, "_latency"}, lat, base + (stall_cnt - stl0));
    check({nm, "_sub_ops"}, sub_cnt - sub0, 4);
    check({nm, "_mix_ops"}, mix_cnt - mix0, v.last ? 0 : 4);
    check({nm, "_hold_errs"}, hold_errs, 0);
    if (release_rsp) begin
      rsp_ready = 1'b1;
      @(posedge g_clk); #1;
      rsp_ready = 1'b0;
      check({nm, "_rsp_drop"}, rsp_valid, 0);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    wait_ready(nm);
    issue(v);
    finish(v, nm, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] s0, k1, r1, sr, held;
    logic [7:0]   inv;
    int           stl_ph;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);

    g_resetn = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_enc = 1'b0; req_last = 1'b0; req_state = '0; req_key = '0;

    s0 = bs(128'h193de3bea0f4e22b9ac68d2ae9f84808);
    k1 = bs(128'ha0fafe1788542cb123a339392a6c7605);
    r1 = bs(128'ha49c7ff2689f352b6b5bea43026a5049);
    sr = bs(128'hd4bf5d30e0b452aeb84111f11e2798e5);
    vecs[0] = '{enc: 1'b1, last: 1'b0, st: s0, key: k1,  exp: r1};
    vecs[1] = '{enc: 1'b1, last: 1'b1, st: s0, key: '0,  exp: sr};
    vecs[2] = '{enc: 1'b0, last: 1'b1, st: sr, key: '0,  exp: s0};
    vecs[3] = '{enc: 1'b1, last: 1'b1, st: s0, key: k1,  exp: sr ^ k1};

    repeat (3) @(posedge g_clk);
    #1 g_resetn = 1'b1;
    check("rst_req_ready", req_ready, 1);
    check("rst_aes_valid", aes_valid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_state", rsp_state, 0);
    check("rst_aes_rs1", aes_rs1, 0);
    check("rst_aes_rs2", aes_rs2, 0);

    check("model_mix_enc", mixcol(32'h455313db, 1'b1), 32'hbca14d8e);
    check("model_mix_dec", mixcol(32'hbca14d8e, 1'b0), 32'h455313db);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("zw_v%0d", i));

    rand_wait = 1'b1;
    stl_ph = stall_cnt;
    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("rw_v%0d", i));
    check("rw_stalls_seen", stall_cnt > stl_ph, 1);
    rand_wait = 1'b0;

    // Response back-pressure with a second request waiting during DONE
    wait_ready("bp");
    issue(vecs[0]);
    finish(vecs[0], "bp_first", 1'b0);
    held = rsp_state;
    req_valid = 1'b1; req_enc = vecs[1].enc; req_last = vecs[1].last;
    req_state = vecs[1].st; req_key = vecs[1].key;
    for (int c = 0; c < 5; c++) begin
      @(posedge g_clk); #1;
      check($sformatf("bp_state_c%0d", c), rsp_state, held);
      check($sformatf("bp_req_ready_c%0d", c), req_ready, 0);
      check($sformatf("bp_no_accept_c%0d", c), aes_valid, 0);
    end
    rsp_ready = 1'b1;
    @(posedge g_clk); #1;
    rsp_ready = 1'b0;
    check("bp_rsp_drop", rsp_valid, 0);
    check("bp_idle_ready", req_ready, 1);
    issue(vecs[1]);
    finish(vecs[1], "bp_second", 1'b1);

    // Reset while column 2 is in its mix op
    wait_ready("rst_mid");
    issue(vecs[0]);
    repeat (5) begin
      @(posedge g_clk); #1;
    end
    check("mid_in_mix", {aes_valid, aes_sub}, 2'b10);
    check("mid_mix_count", mix_cnt - mix0, 2);
    g_resetn = 1'b0;
    @(posedge g_clk); #1;
    g_resetn = 1'b1;
    check("mid_rst_aes_valid", aes_valid, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_req_ready", req_ready, 1);
    run_vec(vecs[0], "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
